booth_nibble_frontend: RTL and testbench
========================================

// Module: booth_nibble_frontend
// PURPOSE
//  Pin-limited I/O stage wrapped around the 8x8 registered Booth multiplier core.
//  - Assembles multiplicand and multiplier from a 4-bit valid/ready input stream and drives them to the core.
//  - Waits out the core's registered-product latency, captures the 16-bit product, and streams it out as 4-bit nibbles.
//  - Sits between the pad ring and the multiplier core; one multiply in flight at a time.
// PARAMETERS
//  NIB_W     4  nibble bus width; OP_W must be a multiple of NIB_W
//  OP_W      8  operand width; product width is 2*OP_W
//  PROD_LAT  1  clk edges from operand-register update to core product register valid; legal range 1..7
// PORTS
//  clk           in   1       rising-edge clock; the core uses the same clock
//  rst_n         in   1       asynchronous active-low reset, synchronous deassert at pad level
//  in_valid      in   1       in_nib holds a valid nibble
//  in_ready      out  1       frontend accepts the nibble on this edge when in_valid=1
//  in_nib        in   NIB_W   operand nibble
//  multiplicand  out  OP_W    registered operand to the core
//  multiplier    out  OP_W    registered operand to the core
//  product       in   2*OP_W  registered product from the core
//  out_valid     out  1       out_nib holds a valid result nibble
//  out_ready     in   1       consumer takes the nibble on this edge when out_valid=1
//  out_nib       out  NIB_W   result nibble
//  busy          out  1       high in every state except LOAD
// BEHAVIOUR
//  Reset values: state=LOAD, in_ready=1, out_valid=0, out_nib=0, multiplicand=0, multiplier=0, busy=0, nibble count=0.
//  Input order, LSB nibble first: mcand[3:0], mcand[7:4], mplier[3:0], mplier[7:4].
//  FSM:
//  - LOAD: in_ready=1. Each in_valid&in_ready edge shifts a nibble into a 16-bit staging register and increments the count.
//    On the 4th accepted nibble, multiplicand and multiplier update on that same edge, then go to WAIT.
//  - WAIT: in_ready=0. A down-counter is loaded with PROD_LAT; after PROD_LAT edges go to CAPTURE.
//  - CAPTURE: one cycle. The product is latched into the result shift register, then go to SEND.
//  - SEND: out_valid=1 and out_nib = result[3:0].
//    Each out_valid&out_ready edge shifts the result right by NIB_W and increments the count.
//    After the last nibble, go to LOAD with the count cleared.
//  Latency: 4th input acceptance to first out_valid = PROD_LAT+2 cycles.
//  Back-pressure: while out_ready=0, out_nib and out_valid hold stable. in_ready stays 0 in WAIT, CAPTURE and SEND.
//  Operand hold: multiplicand and multiplier hold their values until the next 4th-nibble acceptance, so the core output stays stable.
//  Output width: product is passed through unmodified, two's complement, no sign handling in this block.
//  Reset mid-operation: any partial input or output transfer is discarded and the block returns to LOAD.
//  No simultaneous in/out transfers are possible, because in_ready=0 whenever out_valid=1.
// CONFIGURATION
//  BOOTH_FE_PARITY_EN
//  - Defined: SEND emits a 5th nibble equal to the XOR of the four product nibbles before returning to LOAD.
//  - Undefined: exactly 4 output nibbles and no parity logic.
// STRUCTURE
//  Package booth_fe_pkg holds:
//  - state encoding localparams LOAD/WAIT/CAPTURE/SEND, 2 bits
//  - NIBS_IN = 2*OP_W/NIB_W
//  - NIBS_OUT = 2*OP_W/NIB_W (+1 under BOOTH_FE_PARITY_EN)
//  - counter width
//  Sub-module booth_nib_shreg: a parameterised nibble shift register with a load/shift-in/shift-out port.
//  It is instanced twice, once as the input staging register and once as the result register.
// TESTING
//  - mcand=3, mplier=-2: in 3,0,E,F -> out A,F,F,F (0xFFFA); with parity, 5th nibble = 5.
//  - mcand=-128, mplier=-128: in 0,8,0,8 -> out 0,0,0,4 (0x4000).
//  - out_ready held low 5 cycles during SEND of 0x1234: out_nib stays 4 with out_valid=1; then 4,3,2,1 in order.
//  - in_valid asserted during WAIT and SEND: in_ready=0 and no nibble is consumed; the next operand load starts only after the final output nibble.
//  - rst_n pulsed low after 2 input nibbles: all outputs return to reset values; a fresh 4-nibble load of 5,0,7,0 (5x7) -> 3,2,0,0 (0x0023).
//  - Back-to-back multiplies 0x7F x 0x7F then 0x01 x 0xFF: outputs 1,0,F,3 (0x3F01) then F,F,F,F (0xFFFF) with no lost nibbles.

Source files
------------

// File: rtl/booth_fe_pkg.sv
// Shared encodings and sizing helpers for the Booth multiplier nibble frontend.
// Latency: n/a (declarations only).
// Backpressure: n/a. Optional parity nibble enabled by defining BOOTH_FE_PARITY_EN.
package booth_fe_pkg;

  // FSM state encoding, 2 bits
  localparam logic [1:0] LOAD    = 2'd0;
  localparam logic [1:0] WAIT    = 2'd1;
  localparam logic [1:0] CAPTURE = 2'd2;
  localparam logic [1:0] SEND    = 2'd3;

  // Default datapath geometry
  localparam int FE_NIB_W = 4;
  localparam int FE_OP_W  = 8;

  // Extra output nibbles appended after the product
`ifdef BOOTH_FE_PARITY_EN
  localparam int PAR_NIBS = 1;
`else
  localparam int PAR_NIBS = 0;
`endif

  // Wait down-counter width; covers PROD_LAT up to 7
  localparam int LAT_W = 3;

  // Nibbles needed to carry both operands (equals nibbles in the product)
  function automatic int nibs_in(input int op_w, input int nib_w);
    return (2 * op_w) / nib_w;
  endfunction

  // Nibbles streamed out per multiply
  function automatic int nibs_out(input int op_w, input int nib_w);
    return nibs_in(op_w, nib_w) + PAR_NIBS;
  endfunction

  // Counter width able to hold 0..n-1 (at least 1 bit)
  function automatic int cnt_width(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

  localparam int NIBS_IN  = nibs_in(FE_OP_W, FE_NIB_W);
  localparam int NIBS_OUT = nibs_out(FE_OP_W, FE_NIB_W);
  localparam int CNT_W    = cnt_width(NIBS_OUT);

endpackage

// File: rtl/booth_nib_shreg.sv
// Nibble shift register: parallel load, nibble shift-in at the MSB end, shift-out toward the LSB.
// Latency: every operation takes effect on the next clk edge.
// Backpressure: none; the owner decides when to load or shift.
module booth_nib_shreg #(
  parameter int NIB_W = 4,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   load,
  input  logic [NIB_W*DEPTH-1:0] load_dat,
  input  logic                   shift_in,
  input  logic [NIB_W-1:0]       in_nib,
  input  logic                   shift_out,
  output logic [NIB_W*DEPTH-1:0] dat
);

  localparam int W = NIB_W * DEPTH;

  // Load has priority over shifting; shift-in has priority over shift-out
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dat <= '0;
    end else if (load) begin
      dat <= load_dat;
    end else if (shift_in) begin
      dat <= {in_nib, dat[W-1:NIB_W]};
    end else if (shift_out) begin
      dat <= {{NIB_W{1'b0}}, dat[W-1:NIB_W]};
    end
  end

endmodule

// File: rtl/booth_nibble_frontend.sv
// Pin-limited I/O stage: gathers operands from a nibble stream, waits on the core, streams the product out.
// Latency: 4th input nibble accepted -> first out_valid is PROD_LAT+2 cycles; one multiply in flight.
// Backpressure: in_ready low outside LOAD; out_nib/out_valid hold while out_ready=0. Parity nibble under BOOTH_FE_PARITY_EN.
module booth_nibble_frontend
  import booth_fe_pkg::*;
#(
  parameter int NIB_W    = 4,
  parameter int OP_W     = 8,
  parameter int PROD_LAT = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [NIB_W-1:0]    in_nib,
  output logic [OP_W-1:0]     multiplicand,
  output logic [OP_W-1:0]     multiplier,
  input  logic [2*OP_W-1:0]   product,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [NIB_W-1:0]    out_nib,
  output logic                busy
);

  localparam int N_IN  = nibs_in(OP_W, NIB_W);
  localparam int N_OUT = nibs_out(OP_W, NIB_W);
  localparam int CW    = cnt_width(N_OUT);
  localparam int SW    = 2 * OP_W;
  localparam int RW    = N_OUT * NIB_W;

  logic [1:0]       state;
  logic [CW-1:0]    cnt;
  logic [LAT_W-1:0] lat_cnt;
  logic [SW-1:0]    stage_dat;
  logic [SW-1:0]    stage_next;
  logic [RW-1:0]    res_dat;
  logic [RW-1:0]    res_load;
  logic             in_xfer;
  logic             out_xfer;
  logic             last_in;
  logic             last_out;
  logic             unused_bits;

  assign in_ready  = (state == LOAD);
  assign out_valid = (state == SEND);
  assign busy      = (state != LOAD);
  assign out_nib   = res_dat[NIB_W-1:0];

  assign in_xfer  = in_valid & in_ready;
  assign out_xfer = out_valid & out_ready;
  assign last_in  = (cnt == CW'(N_IN - 1));
  assign last_out = (cnt == CW'(N_OUT - 1));

  // Staging contents as they will be after the current nibble shifts in;
  // lets the operands update on the same edge as the final nibble.
  assign stage_next = {in_nib, stage_dat[SW-1:NIB_W]};

  // Only the low nibble of the result is ever presented, and the oldest
  // staged nibble is always shifted past before the operands are taken.
  assign unused_bits = ^{res_dat[RW-1:NIB_W], stage_dat[NIB_W-1:0]};

`ifdef BOOTH_FE_PARITY_EN
  logic [NIB_W-1:0] par;

  // XOR of all product nibbles, sent after the product
  always_comb begin
    par = '0;
    for (int i = 0; i < N_IN; i++) begin
      par = par ^ product[i*NIB_W +: NIB_W];
    end
  end

  assign res_load = {par, product};
`else
  assign res_load = product;
`endif

  booth_nib_shreg #(
    .NIB_W (NIB_W),
    .DEPTH (N_IN)
  ) u_stage (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (1'b0),
    .load_dat  ({SW{1'b0}}),
    .shift_in  (in_xfer),
    .in_nib    (in_nib),
    .shift_out (1'b0),
    .dat       (stage_dat)
  );

  booth_nib_shreg #(
    .NIB_W (NIB_W),
    .DEPTH (N_OUT)
  ) u_result (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (state == CAPTURE),
    .load_dat  (res_load),
    .shift_in  (1'b0),
    .in_nib    ({NIB_W{1'b0}}),
    .shift_out (out_xfer),
    .dat       (res_dat)
  );

  // Operands to the core change only when a complete operand pair arrives
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      multiplicand <= '0;
      multiplier   <= '0;
    end else if (in_xfer && last_in) begin
      {multiplier, multiplicand} <= stage_next;
    end
  end

  // Sequencing: collect operands, wait out core latency, capture, stream result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= LOAD;
      cnt     <= '0;
      lat_cnt <= '0;
    end else begin
      case (state)
        LOAD: begin
          if (in_xfer) begin
            if (last_in) begin
              cnt     <= '0;
              lat_cnt <= LAT_W'(PROD_LAT);
              state   <= WAIT;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        WAIT: begin
          if (lat_cnt == LAT_W'(1)) begin
            state <= CAPTURE;
          end else begin
            lat_cnt <= lat_cnt - 1'b1;
          end
        end
        CAPTURE: begin
          state <= SEND;
        end
        SEND: begin
          if (out_xfer) begin
            if (last_out) begin
              cnt   <= '0;
              state <= LOAD;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        default: begin
          state <= LOAD;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_booth_nibble_frontend.sv
// Bench for booth_nibble_frontend with a behavioural multiplier core beside it.
// Directed cases followed by random operand pairs with random output stalls.
// Parity nibble expected when BOOTH_FE_PARITY_EN is defined.
module tb_booth_nibble_frontend;

  localparam int PROD_LAT = 1;
`ifdef BOOTH_FE_PARITY_EN
  localparam int NOUT = 5;
`else
  localparam int NOUT = 4;
`endif

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_nib;
  logic [7:0]  multiplicand;
  logic [7:0]  multiplier;
  logic [15:0] product;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_nib;
  logic        busy;

  logic        ovr_en;
  logic [15:0] ovr_val;

  int checks;
  int errors;

  booth_nibble_frontend #(
    .NIB_W    (4),
    .OP_W     (8),
    .PROD_LAT (PROD_LAT)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_nib       (in_nib),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .product      (product),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_nib      (out_nib),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stand-in for the registered multiplier core; can be overridden with a fixed product
  always @(posedge clk) begin
    if (ovr_en) product <= ovr_val;
    else        product <= 16'(int'($signed(multiplicand)) * int'($signed(multiplier)));
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present one nibble and hold it until accepted; returns at the negedge after the transfer
  task automatic push(input logic [3:0] n);
    int t;
    t = 0;
    in_valid = 1'b1;
    in_nib   = n;
    while (!in_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (t >= 100) chk("push_timeout", 32'(t), 32'd0);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Take one nibble after 'pre' idle cycles and compare it with the expected value
  task automatic pop(input string tag, input logic [3:0] exp, input int pre);
    int t;
    out_ready = 1'b0;
    for (int k = 0; k < pre; k++) @(negedge clk);
    out_ready = 1'b1;
    t = 0;
    while (!out_valid && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (t >= 100) chk("pop_timeout", 32'(t), 32'd0);
    chk(tag, 32'(out_nib), 32'(exp));
    chk("in_ready_in_send", 32'(in_ready), 32'd0);
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  // One complete multiply: load four nibbles, check latency, stream and check every output nibble
  task automatic do_mul(input logic [7:0] mc, input logic [7:0] mp, input logic [15:0] exp_p,
                        input int stall, input logic junk, input logic rnd_pops);
    int t;
    logic [3:0] exp_n;
    push(mc[3:0]);
    push(mc[7:4]);
    push(mp[3:0]);
    push(mp[7:4]);
    if (junk) begin
      in_valid = 1'b1;
      in_nib   = 4'h9;
    end
    chk("mcand", 32'(multiplicand), 32'(mc));
    chk("mplier", 32'(multiplier), 32'(mp));
    t = 0;
    while (!out_valid && t < 50) begin
      chk("in_ready_busy_wait", {30'd0, in_ready, busy}, 32'd1);
      @(negedge clk);
      t++;
    end
    chk("latency", 32'(t + 1), 32'(PROD_LAT + 2));
    for (int s = 0; s < stall; s++) begin
      chk("stall_valid", 32'(out_valid), 32'd1);
      chk("stall_nib", 32'(out_nib), 32'(exp_p[3:0]));
      @(negedge clk);
    end
    for (int i = 0; i < NOUT; i++) begin
      if (i < 4) exp_n = exp_p[i*4 +: 4];
      else       exp_n = exp_p[3:0] ^ exp_p[7:4] ^ exp_p[11:8] ^ exp_p[15:12];
      pop("out_nib", exp_n, rnd_pops ? int'($urandom_range(0, 2)) : 0);
    end
    in_valid = 1'b0;
    chk("idle_after", {29'd0, in_ready, busy, out_valid}, 32'd4);
  endtask

  initial begin
    logic [7:0]  rmc;
    logic [7:0]  rmp;
    logic [15:0] rp;
    checks    = 0;
    errors    = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_nib    = 4'h0;
    out_ready = 1'b0;
    ovr_en    = 1'b0;
    ovr_val   = 16'h0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_nib", 32'(out_nib), 32'd0);
    chk("rst_mcand", 32'(multiplicand), 32'd0);
    chk("rst_mplier", 32'(multiplier), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // 3 x -2 = 0xFFFA
    do_mul(8'h03, 8'hFE, 16'hFFFA, 0, 1'b0, 1'b0);
    // -128 x -128 = 0x4000
    do_mul(8'h80, 8'h80, 16'h4000, 0, 1'b0, 1'b0);

    // Back-pressure on a forced product of 0x1234
    ovr_en  = 1'b1;
    ovr_val = 16'h1234;
    do_mul(8'h11, 8'h22, 16'h1234, 5, 1'b0, 1'b0);
    ovr_en  = 1'b0;

    // in_valid held through WAIT/SEND: nothing consumed, operands held
    do_mul(8'h12, 8'h03, 16'h0036, 2, 1'b1, 1'b0);
    chk("operand_hold_mcand", 32'(multiplicand), 32'h12);
    chk("operand_hold_mplier", 32'(multiplier), 32'h03);

    // Reset in the middle of an operand load
    push(4'h3);
    push(4'h0);
    rst_n = 1'b0;
    #1;
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_out_nib", 32'(out_nib), 32'd0);
    chk("midrst_mcand", 32'(multiplicand), 32'd0);
    chk("midrst_mplier", 32'(multiplier), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    do_mul(8'h05, 8'h07, 16'h0023, 0, 1'b0, 1'b0);

    // Back-to-back multiplies
    do_mul(8'h7F, 8'h7F, 16'h3F01, 0, 1'b0, 1'b0);
    do_mul(8'h01, 8'hFF, 16'hFFFF, 0, 1'b0, 1'b0);

    // Random operands against the arithmetic reference
    for (int r = 0; r < 12; r++) begin
      rmc = 8'($urandom);
      rmp = 8'($urandom);
      rp  = 16'(int'($signed(rmc)) * int'($signed(rmp)));
      do_mul(rmc, rmp, rp, int'($urandom_range(0, 3)), 1'b0, 1'b1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
